pipe_skid_stage: RTL and testbench

Parametrised, elastic pipeline-stage register that replaces the fixed-field enable/reset stage registers between CPU pipeline stages, for example MEM/WB. It carries an opaque DATA_W-bit payload under a valid/ready handshake, with a 2-entry skid buffer so that in_ready is registered. It adds synchronous flush and bubble zeroing, neither of which the fixed registers have. The instance between MEM and WB packs {RegWrite, MemtoReg, RD[31:0], ALU[31:0], WN[4:0]} = 71 bits.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_skid_stage.sv | 84 ++++++++
 tb/tb_pipe_skid_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MEM/WB payload layout and skid-stage state encodings.
package pipe_pkg;

    localparam int MEMWB_W = 71;

    localparam int WN_LSB       = 0;
    localparam int WN_MSB       = 4;
    localparam int ALU_LSB      = 5;
    localparam int ALU_MSB      = 36;
    localparam int RD_LSB       = 37;
    localparam int RD_MSB       = 68;
    localparam int MEMTOREG_BIT = 69;
    localparam int REGWRITE_BIT = 70;

    // Encoding is {skid_v, main_v}; 2'b10 can never be reached.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer so in_ready is a flop output.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W      = MEMWB_W,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    skid_state_t       state;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;
    logic              main_v;
    logic              skid_v;
    logic              acc;
    logic              pop;

    assign main_v    = state[0];
    assign skid_v    = state[1];
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
    assign acc       = in_valid & in_ready;
    assign pop       = main_v & out_ready;

    // Flush wins over any concurrent accept or pop; invalidated entries are zeroed when ZERO_BUBBLE is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_EMPTY;
            main_d <= '0;
            skid_d <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
            if (ZERO_BUBBLE) begin
                main_d <= '0;
                skid_d <= '0;
            end
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        main_d <= in_data;
                        state  <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && pop) begin
                        main_d <= in_data;
                    end else if (acc) begin
                        skid_d <= in_data;
                        state  <= ST_FULL;
                    end else if (pop) begin
                        state <= ST_EMPTY;
                        if (ZERO_BUBBLE) main_d <= '0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        main_d <= skid_d;
                        state  <= ST_ONE;
                        if (ZERO_BUBBLE) skid_d <= '0;
                    end
                end
                default: begin
                    state  <= ST_EMPTY;
                    main_d <= '0;
                    skid_d <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench: two stage instances (zeroing and stale-hold) against a queue-based FIFO model.
module tb_pipe_skid_stage;

    localparam int W = 71;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic         zb_in_ready, zb_out_valid;
    logic [W-1:0] zb_out_data;
    logic [1:0]   zb_occupancy;
    logic         hd_in_ready, hd_out_valid;
    logic [W-1:0] hd_out_data;
    logic [1:0]   hd_occupancy;

    logic [W-1:0] model_q[$];
    logic [W-1:0] stale = '0;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(W), .ZERO_BUBBLE(1'b1)) dut_zb (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(zb_in_ready), .in_data(in_data),
        .out_valid(zb_out_valid), .out_ready(out_ready), .out_data(zb_out_data),
        .occupancy(zb_occupancy)
    );

    pipe_skid_stage #(.DATA_W(W), .ZERO_BUBBLE(1'b0)) dut_hold (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(hd_in_ready), .in_data(in_data),
        .out_valid(hd_out_valid), .out_ready(out_ready), .out_data(hd_out_data),
        .occupancy(hd_occupancy)
    );

    task automatic checkVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow purely from the FIFO contents: at most two entries, front is visible.
    task automatic checkOutput(input string step);
        logic [W-1:0] exp_front;
        logic [W-1:0] exp_stale;
        logic [W-1:0] exp_occ;
        logic [W-1:0] exp_valid;
        logic [W-1:0] exp_ready;
        exp_occ   = W'(model_q.size());
        exp_valid = W'(model_q.size() > 0);
        exp_ready = W'(model_q.size() < 2);
        exp_front = (model_q.size() > 0) ? model_q[0] : '0;
        exp_stale = (model_q.size() > 0) ? model_q[0] : stale;
        checkVal({step, " zb.out_valid"}, W'(zb_out_valid), exp_valid);
        checkVal({step, " zb.in_ready"},  W'(zb_in_ready),  exp_ready);
        checkVal({step, " zb.occupancy"}, W'(zb_occupancy), exp_occ);
        checkVal({step, " zb.out_data"},  zb_out_data,      exp_front);
        checkVal({step, " hd.out_valid"}, W'(hd_out_valid), exp_valid);
        checkVal({step, " hd.in_ready"},  W'(hd_in_ready),  exp_ready);
        checkVal({step, " hd.occupancy"}, W'(hd_occupancy), exp_occ);
        checkVal({step, " hd.out_data"},  hd_out_data,      exp_stale);
    endtask

    task automatic modelStep();
        bit acc;
        bit pop;
        acc = in_valid && (model_q.size() < 2);
        pop = out_ready && (model_q.size() > 0);
        if (flush) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (acc) model_q.push_back(in_data);
        end
        if (model_q.size() > 0) stale = model_q[0];
    endtask

    // Called at a falling edge: drive inputs, check current outputs, then advance one clock.
    task automatic applyStimulus(input string step, input logic iv, input logic [W-1:0] d,
                                 input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        checkOutput(step);
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] randData();
        return {7'($urandom()), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [75:0]  raw;
        logic [W-1:0] first_word;
        raw        = 76'h5_0000_0010_0000_0020_03;
        first_word = raw[W-1:0];

        @(negedge clk);
        #1;
        checkOutput("reset held");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] single transfer");
        applyStimulus("t1 accept", 1'b1, first_word, 1'b1, 1'b0);
        applyStimulus("t1 output", 1'b0, '0, 1'b1, 1'b0);
        applyStimulus("t1 drained", 1'b0, '0, 1'b1, 1'b0);

        $display("[TB] streaming 1..8");
        for (int i = 1; i <= 8; i++) applyStimulus("t2 stream", 1'b1, W'(i), 1'b1, 1'b0);
        applyStimulus("t2 tail", 1'b0, '0, 1'b1, 1'b0);
        applyStimulus("t2 empty", 1'b0, '0, 1'b1, 1'b0);

        $display("[TB] backpressure A,B,C");
        applyStimulus("t3 A", 1'b1, W'(71'hA), 1'b1, 1'b0);
        applyStimulus("t3 B", 1'b1, W'(71'hB), 1'b0, 1'b0);
        applyStimulus("t3 C blocked", 1'b1, W'(71'hC), 1'b0, 1'b0);
        applyStimulus("t3 C blocked", 1'b1, W'(71'hC), 1'b0, 1'b0);
        applyStimulus("t3 release", 1'b1, W'(71'hC), 1'b1, 1'b0);
        applyStimulus("t3 C accept", 1'b1, W'(71'hC), 1'b1, 1'b0);
        applyStimulus("t3 drain", 1'b0, '0, 1'b1, 1'b0);
        applyStimulus("t3 empty", 1'b0, '0, 1'b1, 1'b0);

        $display("[TB] flush from FULL");
        applyStimulus("t4 fill1", 1'b1, W'(71'h11), 1'b0, 1'b0);
        applyStimulus("t4 fill2", 1'b1, W'(71'h22), 1'b0, 1'b0);
        applyStimulus("t4 flush", 1'b1, W'(71'hDD), 1'b0, 1'b1);
        applyStimulus("t4 after", 1'b0, '0, 1'b1, 1'b0);
        applyStimulus("t4 idle", 1'b0, '0, 1'b1, 1'b0);

        $display("[TB] async reset while FULL");
        applyStimulus("t5 fill1", 1'b1, W'(71'h33), 1'b0, 1'b0);
        applyStimulus("t5 fill2", 1'b1, W'(71'h44), 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = W'(71'h55);
        #2;
        rst = 1'b1;
        model_q.delete();
        stale = '0;
        #1;
        checkOutput("t5 in reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("t5 resume", 1'b1, W'(71'h66), 1'b1, 1'b0);
        applyStimulus("t5 output", 1'b0, '0, 1'b1, 1'b0);

        $display("[TB] bubble vs stale hold");
        applyStimulus("t6 last pop", 1'b0, '0, 1'b1, 1'b0);
        checkVal("t6 hd keeps stale", hd_out_data, W'(71'h66));
        checkVal("t6 zb zeroed", zb_out_data, '0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 3) != 0), randData(),
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end
        applyStimulus("rand drain", 1'b0, '0, 1'b1, 1'b0);
        applyStimulus("rand drain", 1'b0, '0, 1'b1, 1'b0);
        applyStimulus("rand drain", 1'b0, '0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
